// File: rtl/br_hazard_ctrl_pkg.sv
// Shared definitions for the branch hazard controller.
//   - br_state_e : controller FSM state codes (RUN / STALL / HOLD)
//   - STALL_*    : bubble counts required per producer type
//   - REG_ZERO   : hard-wired zero register index (never a hazard source)
//   - max_stall  : larger of two stall requirements
package br_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HOLD  = 2'd2
  } br_state_e;

  localparam logic [1:0] STALL_EX_LOAD  = 2'd2;
  localparam logic [1:0] STALL_EX_ALU   = 2'd1;
  localparam logic [1:0] STALL_MEM_LOAD = 2'd1;

  localparam int unsigned REG_ZERO = 0;

  function automatic logic [1:0] max_stall(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/br_hazard_ctrl_if.sv
// Bundle between the branch hazard controller and its neighbours
// (ID stage / branch judge, EX and MEM writer info, PC/fetch).
//   master : pipeline side, drives ID/EX/MEM info and fetch_ready,
//            receives stall/bubble/redirect controls.
//   slave  : br_hazard_ctrl side.
// Parameters: AW = PC/target width, RW = register-index width.
interface br_hazard_ctrl_if #(
  parameter int AW = 32,
  parameter int RW = 5
);
  // ID stage / branch judge
  logic          id_valid;
  logic          id_is_br;
  logic          id_br_flag;
  logic [AW-1:0] id_br_addr;
  logic          id_use_rs;
  logic          id_use_rt;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  // older instructions still in flight
  logic          ex_wr;
  logic          ex_load;
  logic [RW-1:0] ex_rd;
  logic          mem_wr;
  logic          mem_load;
  logic [RW-1:0] mem_rd;
  // fetch handshake
  logic          fetch_ready;
  // controls back to the pipeline
  logic          pc_stall;
  logic          ifid_stall;
  logic          idex_bubble;
  logic          redir_valid;
  logic [AW-1:0] redir_addr;
  logic          br_busy;

  modport master (
    output id_valid, id_is_br, id_br_flag, id_br_addr, id_use_rs, id_use_rt,
           id_rs, id_rt, ex_wr, ex_load, ex_rd, mem_wr, mem_load, mem_rd,
           fetch_ready,
    input  pc_stall, ifid_stall, idex_bubble, redir_valid, redir_addr, br_busy
  );

  modport slave (
    input  id_valid, id_is_br, id_br_flag, id_br_addr, id_use_rs, id_use_rt,
           id_rs, id_rt, ex_wr, ex_load, ex_rd, mem_wr, mem_load, mem_rd,
           fetch_ready,
    output pc_stall, ifid_stall, idex_bubble, redir_valid, redir_addr, br_busy
  );

endinterface

// File: rtl/br_hazard_ctrl_operand_hazard.sv
// br_operand_hazard: combinational stall-count evaluation for the branch
// operands read in ID.
// Ports:
//   use_rs/use_rt, rs/rt         : which sources the branch reads, and their indices
//   ex_wr/ex_load/ex_rd          : EX-stage writer (load or ALU)
//   mem_wr/mem_load/mem_rd       : MEM-stage writer (load or ALU)
//   stall_n                      : bubbles needed before the compare is safe (0..2)
// A MEM-stage ALU result is forwarded into the ID compare, so only a MEM
// load costs a bubble there. The requirement is the max over rs and rt.
module br_operand_hazard
  import br_hazard_ctrl_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          use_rs,
  input  logic          use_rt,
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  input  logic          ex_wr,
  input  logic          ex_load,
  input  logic [RW-1:0] ex_rd,
  input  logic          mem_wr,
  input  logic          mem_load,
  input  logic [RW-1:0] mem_rd,
  output logic [1:0]    stall_n
);

  function automatic logic [1:0] src_need(
    input logic          use_src,
    input logic [RW-1:0] idx,
    input logic          exw,
    input logic          exl,
    input logic [RW-1:0] exd,
    input logic          mw,
    input logic          ml,
    input logic [RW-1:0] md
  );
    logic [1:0] ex_n;
    logic [1:0] mem_n;
    ex_n  = 2'd0;
    mem_n = 2'd0;
    if (use_src && (idx != RW'(REG_ZERO))) begin
      // a load always writes its destination, even if the write bit is not echoed
      if ((exw | exl) && (exd == idx)) begin
        ex_n = exl ? STALL_EX_LOAD : STALL_EX_ALU;
      end
      if ((mw | ml) && ml && (md == idx)) begin
        mem_n = STALL_MEM_LOAD;
      end
    end
    return max_stall(ex_n, mem_n);
  endfunction

  logic [1:0] rs_n;
  logic [1:0] rt_n;

  always_comb begin
    rs_n    = src_need(use_rs, rs, ex_wr, ex_load, ex_rd, mem_wr, mem_load, mem_rd);
    rt_n    = src_need(use_rt, rt, ex_wr, ex_load, ex_rd, mem_wr, mem_load, mem_rd);
    stall_n = max_stall(rs_n, rt_n);
  end

endmodule

// File: rtl/br_hazard_ctrl.sv
// br_hazard_ctrl: ID-stage branch sequencing.
//   Detects operand hazards on a branch in ID, stalls PC and IF/ID while
//   injecting ID/EX bubbles for the required number of cycles, then issues
//   the PC redirect. A redirect that fetch cannot take immediately is held
//   in a target register (HOLD) until fetch_ready.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   bus (slave)   : ID/EX/MEM info and fetch_ready in;
//                   pc_stall, ifid_stall, idex_bubble, redir_valid,
//                   redir_addr, br_busy out
//   stat_br/stat_taken/stat_stall (BR_STAT_EN only): branches resolved,
//                   redirects accepted, cycles with pc_stall high
// Configuration macro: BR_STAT_EN enables the statistic counters and ports.
module br_hazard_ctrl
  import br_hazard_ctrl_pkg::*;
#(
  parameter int AW = 32,
  parameter int RW = 5
`ifdef BR_STAT_EN
  ,
  parameter int STAT_W = 32
`endif
) (
  input  logic clk,
  input  logic rst,
  br_hazard_ctrl_if.slave bus
`ifdef BR_STAT_EN
  ,
  output logic [STAT_W-1:0] stat_br,
  output logic [STAT_W-1:0] stat_taken,
  output logic [STAT_W-1:0] stat_stall
`endif
);

  br_state_e     state;
  logic [1:0]    stall_cnt;
  logic [AW-1:0] tgt_q;
  logic          rst_q;

  logic          blk;
  logic          br_req;
  logic [1:0]    need;
  logic          resolve;

  logic          pc_stall;
  logic          ifid_stall;
  logic          idex_bubble;
  logic          redir_valid;
  logic [AW-1:0] redir_addr;

  br_operand_hazard #(.RW(RW)) u_hazard (
    .use_rs   (bus.id_use_rs),
    .use_rt   (bus.id_use_rt),
    .rs       (bus.id_rs),
    .rt       (bus.id_rt),
    .ex_wr    (bus.ex_wr),
    .ex_load  (bus.ex_load),
    .ex_rd    (bus.ex_rd),
    .mem_wr   (bus.mem_wr),
    .mem_load (bus.mem_load),
    .mem_rd   (bus.mem_rd),
    .stall_n  (need)
  );

  // Outputs stay quiet in the reset cycle and the one after it, so the
  // pipeline sees a clean start even if ID already presents a branch.
  assign blk     = rst | rst_q;
  assign br_req  = bus.id_valid & bus.id_is_br;
  assign resolve = !blk && (state == ST_RUN) && br_req && (need == 2'd0);

  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    redir_valid = 1'b0;
    redir_addr  = '0;
    if (!blk) begin
      case (state)
        ST_RUN: begin
          if (br_req) begin
            if (need != 2'd0) begin
              pc_stall    = 1'b1;
              ifid_stall  = 1'b1;
              idex_bubble = 1'b1;
            end else if (bus.id_br_flag) begin
              // redirect in the resolve cycle; the delay slot already in IF proceeds
              redir_valid = 1'b1;
              redir_addr  = bus.id_br_addr;
              pc_stall    = !bus.fetch_ready;
            end
          end
        end
        ST_STALL: begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
        end
        ST_HOLD: begin
          redir_valid = 1'b1;
          redir_addr  = tgt_q;
          pc_stall    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_stall    = pc_stall;
  assign bus.ifid_stall  = ifid_stall;
  assign bus.idex_bubble = idex_bubble;
  assign bus.redir_valid = redir_valid;
  assign bus.redir_addr  = redir_addr;
  assign bus.br_busy     = !rst && (state != ST_RUN);

  // Stall count is latched on entry; hazard inputs are not re-examined in
  // STALL. The ID instruction during HOLD is a delay-slot branch and is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      stall_cnt <= 2'd0;
      tgt_q     <= '0;
      rst_q     <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      if (!rst_q) begin
        case (state)
          ST_RUN: begin
            if (br_req) begin
              if (need != 2'd0) begin
                stall_cnt <= need - 2'd1;
                state     <= (need > 2'd1) ? ST_STALL : ST_RUN;
              end else if (bus.id_br_flag && !bus.fetch_ready) begin
                tgt_q <= bus.id_br_addr;
                state <= ST_HOLD;
              end
            end
          end
          ST_STALL: begin
            if (stall_cnt != 2'd0) stall_cnt <= stall_cnt - 2'd1;
            if (stall_cnt <= 2'd1) state <= ST_RUN;
          end
          ST_HOLD: begin
            if (bus.fetch_ready) state <= ST_RUN;
          end
          default: state <= ST_RUN;
        endcase
      end
    end
  end

`ifdef BR_STAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br    <= '0;
      stat_taken <= '0;
      stat_stall <= '0;
    end else begin
      if (resolve)                    stat_br    <= stat_br + 1'b1;
      if (redir_valid && bus.fetch_ready) stat_taken <= stat_taken + 1'b1;
      if (pc_stall)                   stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule
